// File: rtl/display_scanout.sv
// Parametrised raster timing generator with palette lookup and frame-buffer address generation.
// Optional DISPLAY_TEST_PATTERN_EN replaces the fetched pixel index with eight vertical colour bars.
module display_scanout #(
    parameter int H_SYNC     = 64,
    parameter int H_BACK     = 58,
    parameter int H_ACTIVE   = 640,
    parameter int H_TOTAL    = 858,
    parameter int V_SYNC     = 6,
    parameter int V_BACK     = 32,
    parameter int V_ACTIVE   = 400,
    parameter int V_TOTAL    = 525,
    parameter int CLK_DIV    = 2,
    parameter int COLOR_BITS = 4,
    parameter int ADDR_W     = 18,
    parameter int FETCH_LAT  = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  ready,
    input  logic [COLOR_BITS-1:0] color,
    input  logic                  pal_we,
    input  logic [COLOR_BITS-1:0] pal_addr,
    input  logic [9:0]            pal_data,
`ifdef DISPLAY_TEST_PATTERN_EN
    input  logic                  test_pattern,
`endif
    output logic                  hsync,
    output logic                  vsync,
    output logic                  clock_out,
    output logic [3:0]            y,
    output logic [2:0]            cr,
    output logic [2:0]            cb,
    output logic [ADDR_W-1:0]     rd_addr,
    output logic                  de,
    output logic                  frame_start,
    output logic                  underflow
);
    localparam int HW    = $clog2(H_TOTAL);
    localparam int VW    = $clog2(V_TOTAL);
    localparam int DW    = $clog2(CLK_DIV);
    localparam int DEPTH = 1 << COLOR_BITS;
    localparam int H_AS  = H_SYNC + H_BACK;
    localparam int H_AE  = H_AS + H_ACTIVE;
    localparam int V_AS  = V_SYNC + V_BACK;
    localparam int V_AE  = V_AS + V_ACTIVE;
    localparam int H_FS  = H_AS - FETCH_LAT;
    localparam int H_FE  = H_AE - FETCH_LAT;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);
    localparam logic [9:0]    BLACK    = 10'b0001_100_100;

    logic [DW-1:0]         div;
    logic [DW-1:0]         div_n;
    logic                  tick;
    logic [HW-1:0]         h;
    logic [VW-1:0]         v;
    logic                  origin;
    logic                  active;
    logic                  fetch;
    logic                  v_act;
    logic                  frame_ok;
    logic [9:0]            pal [DEPTH];
    logic [COLOR_BITS-1:0] pix_idx;

    function automatic logic [9:0] pal_default(input int idx);
        case (idx)
            0:       return 10'b1001_100_100;
            1:       return 10'b0100_010_111;
            2:       return 10'b0010_110_000;
            3:       return 10'b0000_000_000;
            default: return BLACK;
        endcase
    endfunction

    assign tick   = (div == DIV_LAST);
    assign div_n  = tick ? '0 : div + DW'(1);
    assign origin = (h == '0) && (v == '0);
    assign v_act  = (int'(v) >= V_AS) && (int'(v) < V_AE);
    assign active = (int'(h) >= H_AS) && (int'(h) < H_AE) && v_act;
    // The fetch window leads the active window so the returned index lines up with the first pixel.
    assign fetch  = (int'(h) >= H_FS) && (int'(h) < H_FE) && v_act;

`ifdef DISPLAY_TEST_PATTERN_EN
    int bar_val;
    assign bar_val = ((int'(h) - H_AS) * 8) / H_ACTIVE;
    assign pix_idx = test_pattern ? COLOR_BITS'(bar_val) : color;
`else
    assign pix_idx = color;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            div       <= '0;
            clock_out <= 1'b0;
        end else begin
            div       <= div_n;
            clock_out <= (div_n >= DIV_HALF);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            h <= '0;
            v <= '0;
        end else if (tick) begin
            if (int'(h) == H_TOTAL - 1) begin
                h <= '0;
                v <= (int'(v) == V_TOTAL - 1) ? '0 : v + VW'(1);
            end else begin
                h <= h + HW'(1);
            end
        end
    end

    // ready is a level from the frame buffer: sampled once at the frame origin, it admits or skips that whole frame.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hsync       <= 1'b0;
            vsync       <= 1'b0;
            de          <= 1'b0;
            frame_start <= 1'b0;
            underflow   <= 1'b0;
            frame_ok    <= 1'b0;
            rd_addr     <= '0;
            {y, cr, cb} <= BLACK;
        end else begin
            frame_start <= tick && origin;
            if (tick) begin
                hsync <= (int'(h) >= H_SYNC);
                vsync <= (int'(v) >= V_SYNC);
                if (origin) begin
                    frame_ok  <= ready;
                    underflow <= underflow | ~ready;
                    rd_addr   <= '0;
                end else if (fetch && frame_ok) begin
                    rd_addr <= rd_addr + ADDR_W'(1);
                end
                if (active && frame_ok) begin
                    de          <= 1'b1;
                    {y, cr, cb} <= pal[pix_idx];
                end else begin
                    de          <= 1'b0;
                    {y, cr, cb} <= BLACK;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) pal[i] <= pal_default(i);
        end else if (pal_we) begin
            pal[pal_addr] <= pal_data;
        end
    end
endmodule

// File: tb/tb_display_scanout.sv
// Directed bench for display_scanout on a small raster: vector table over the first frame,
// then whole-frame statistics, ready gating, palette writes and a mid-frame reset.
module tb_display_scanout;
    localparam int H_SYNC = 4, H_BACK = 3, H_ACTIVE = 8, H_TOTAL = 20;
    localparam int V_SYNC = 2, V_BACK = 2, V_ACTIVE = 3, V_TOTAL = 9;
    localparam int CLK_DIV = 2, COLOR_BITS = 4, ADDR_W = 8, FETCH_LAT = 2;
    localparam int FRAME_CLK = H_TOTAL * V_TOTAL * CLK_DIV;
    localparam int NVEC = 20;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ready = 1'b1;
    logic [3:0]  color = '0;
    logic        pal_we = 1'b0;
    logic [3:0]  pal_addr = '0;
    logic [9:0]  pal_data = '0;
    logic        hsync, vsync, clock_out, de, frame_start, underflow;
    logic [3:0]  y;
    logic [2:0]  cr, cb;
    logic [7:0]  rd_addr;
`ifdef DISPLAY_TEST_PATTERN_EN
    logic        test_pattern = 1'b0;
`endif

    always #5 clk = ~clk;

    display_scanout #(
        .H_SYNC(H_SYNC), .H_BACK(H_BACK), .H_ACTIVE(H_ACTIVE), .H_TOTAL(H_TOTAL),
        .V_SYNC(V_SYNC), .V_BACK(V_BACK), .V_ACTIVE(V_ACTIVE), .V_TOTAL(V_TOTAL),
        .CLK_DIV(CLK_DIV), .COLOR_BITS(COLOR_BITS), .ADDR_W(ADDR_W), .FETCH_LAT(FETCH_LAT)
    ) dut (
        .clk(clk), .reset_n(reset_n), .ready(ready), .color(color),
        .pal_we(pal_we), .pal_addr(pal_addr), .pal_data(pal_data),
`ifdef DISPLAY_TEST_PATTERN_EN
        .test_pattern(test_pattern),
`endif
        .hsync(hsync), .vsync(vsync), .clock_out(clock_out),
        .y(y), .cr(cr), .cb(cb), .rd_addr(rd_addr), .de(de),
        .frame_start(frame_start), .underflow(underflow)
    );

    typedef struct {
        int         h;
        int         v;
        logic       hs;
        logic       vs;
        logic       de_e;
        logic       fs;
        logic [7:0] addr;
        logic [9:0] pix;
    } vec_t;

    vec_t       vecs [NVEC];
    int         checks = 0;
    int         fails = 0;
    int         e = 0;
    int         cur_h = 0, cur_v = 0;
    bit         at_tick = 0;
    logic [7:0] d1 = '0, d2 = '0, prev_rd = '0;
    bit         ovr = 0;
    logic [3:0] ovr_val = '0;
    int         clk_bad = 0;
    int         last_fs_e = -1, fs_period = 0;
    int         de_cnt, hs_low, vs_low, max_addr, nonblack, addr_fs;

    function automatic vec_t mk(int h, int v, int hs, int vs, int de_e, int fs, int addr, int pix);
        vec_t r;
        r.h = h; r.v = v;
        r.hs = (hs != 0); r.vs = (vs != 0); r.de_e = (de_e != 0); r.fs = (fs != 0);
        r.addr = 8'(addr); r.pix = 10'(pix);
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (h=%0d v=%0d e=%0d)", name, act, exp, cur_h, cur_v, e);
        end
    endtask

    // One clk edge; tracks raster position from the edge count and models a FETCH_LAT=2 frame buffer.
    task automatic step();
        bit exp_co;
        int p;
        @(posedge clk);
        #1;
        e++;
        exp_co = ((e % CLK_DIV) >= (CLK_DIV / 2));
        if (clock_out !== exp_co) clk_bad++;
        at_tick = ((e % CLK_DIV) == 0);
        if (at_tick) begin
            p = (e / CLK_DIV - 1) % (H_TOTAL * V_TOTAL);
            cur_h = p % H_TOTAL;
            cur_v = p / H_TOTAL;
            d2 = d1;
            d1 = prev_rd;
            prev_rd = rd_addr;
        end
        if (frame_start) begin
            if (last_fs_e >= 0) fs_period = e - last_fs_e;
            last_fs_e = e;
        end
        color = ovr ? ovr_val : d2[3:0];
    endtask

    task automatic wait_pos(input int h, input int v);
        for (int i = 0; i < 2 * FRAME_CLK; i++) begin
            step();
            if (at_tick && cur_h == h && cur_v == v) return;
        end
        check("wait_pos_timeout", 32'(1), 32'(0));
    endtask

    task automatic reset_cycles(input int n);
        reset_n = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        check("rst_hsync", 32'(hsync), 32'(0));
        check("rst_vsync", 32'(vsync), 32'(0));
        check("rst_clock_out", 32'(clock_out), 32'(0));
        check("rst_de", 32'(de), 32'(0));
        check("rst_frame_start", 32'(frame_start), 32'(0));
        check("rst_underflow", 32'(underflow), 32'(0));
        check("rst_rd_addr", 32'(rd_addr), 32'(0));
        check("rst_pixel", 32'({y, cr, cb}), 32'(10'h064));
        reset_n = 1'b1;
        e = 0; at_tick = 0; cur_h = 0; cur_v = 0;
        d1 = '0; d2 = '0; prev_rd = '0; ovr = 0;
        color = '0; last_fs_e = -1;
    endtask

    task automatic run_frame();
        de_cnt = 0; hs_low = 0; vs_low = 0; max_addr = 0; nonblack = 0; addr_fs = -1;
        for (int i = 0; i < FRAME_CLK; i++) begin
            step();
            if (frame_start) addr_fs = int'(rd_addr);
            if (at_tick) begin
                if (de) de_cnt++;
                if (!hsync) hs_low++;
                if (!vsync) vs_low++;
                if ({y, cr, cb} != 10'h064) nonblack++;
                if (int'(rd_addr) > max_addr) max_addr = int'(rd_addr);
            end
        end
    endtask

    initial begin
        //           h   v  hs vs de fs addr pix
        vecs[0]  = mk( 0, 0, 0, 0, 0, 1,  0, 'h064);
        vecs[1]  = mk( 3, 0, 0, 0, 0, 0,  0, 'h064);
        vecs[2]  = mk( 4, 0, 1, 0, 0, 0,  0, 'h064);
        vecs[3]  = mk( 0, 2, 0, 1, 0, 0,  0, 'h064);
        vecs[4]  = mk( 5, 4, 1, 1, 0, 0,  1, 'h064);
        vecs[5]  = mk( 6, 4, 1, 1, 0, 0,  2, 'h064);
        vecs[6]  = mk( 7, 4, 1, 1, 1, 0,  3, 'h264);
        vecs[7]  = mk( 8, 4, 1, 1, 1, 0,  4, 'h117);
        vecs[8]  = mk( 9, 4, 1, 1, 1, 0,  5, 'h0B0);
        vecs[9]  = mk(10, 4, 1, 1, 1, 0,  6, 'h000);
        vecs[10] = mk(11, 4, 1, 1, 1, 0,  7, 'h064);
        vecs[11] = mk(12, 4, 1, 1, 1, 0,  8, 'h064);
        vecs[12] = mk(14, 4, 1, 1, 1, 0,  8, 'h064);
        vecs[13] = mk(15, 4, 1, 1, 0, 0,  8, 'h064);
        vecs[14] = mk( 7, 5, 1, 1, 1, 0, 11, 'h064);
        vecs[15] = mk( 7, 6, 1, 1, 1, 0, 19, 'h264);
        vecs[16] = mk( 8, 6, 1, 1, 1, 0, 20, 'h117);
        vecs[17] = mk(14, 6, 1, 1, 1, 0, 24, 'h064);
        vecs[18] = mk( 0, 7, 0, 1, 0, 0, 24, 'h064);
        vecs[19] = mk(19, 8, 1, 1, 0, 0, 24, 'h064);

        reset_cycles(3);

        for (int i = 0; i < NVEC; i++) begin
            wait_pos(vecs[i].h, vecs[i].v);
            check("vec_hsync", 32'(hsync), 32'(vecs[i].hs));
            check("vec_vsync", 32'(vsync), 32'(vecs[i].vs));
            check("vec_de", 32'(de), 32'(vecs[i].de_e));
            check("vec_frame_start", 32'(frame_start), 32'(vecs[i].fs));
            check("vec_rd_addr", 32'(rd_addr), 32'(vecs[i].addr));
            check("vec_pixel", 32'({y, cr, cb}), 32'(vecs[i].pix));
        end
        check("frame0_underflow", 32'(underflow), 32'(0));

        run_frame();
        check("f1_de_ticks", 32'(de_cnt), 32'(24));
        check("f1_hsync_low_ticks", 32'(hs_low), 32'(36));
        check("f1_vsync_low_ticks", 32'(vs_low), 32'(40));
        check("f1_max_rd_addr", 32'(max_addr), 32'(24));
        check("f1_rd_addr_at_origin", 32'(addr_fs), 32'(0));
        check("f1_frame_period_clk", 32'(fs_period), 32'(360));
        check("f1_underflow", 32'(underflow), 32'(0));

        ready = 1'b0;
        run_frame();
        ready = 1'b1;
        check("skip_de_ticks", 32'(de_cnt), 32'(0));
        check("skip_nonblack_ticks", 32'(nonblack), 32'(0));
        check("skip_max_rd_addr", 32'(max_addr), 32'(0));
        check("skip_underflow", 32'(underflow), 32'(1));

        run_frame();
        check("resume_de_ticks", 32'(de_cnt), 32'(24));
        check("resume_max_rd_addr", 32'(max_addr), 32'(24));
        check("resume_underflow_sticky", 32'(underflow), 32'(1));

        // Palette write between ticks, then a write coinciding with the lookup edge.
        wait_pos(6, 4);
        pal_we = 1'b1; pal_addr = 4'd5; pal_data = 10'b1111_011_001;
        ovr = 1; ovr_val = 4'd5; color = 4'd5;
        step();
        pal_we = 1'b0;
        step();
        check("pal5_new_value", 32'({y, cr, cb}), 32'(10'h3D9));
        check("pal5_de", 32'(de), 32'(1));
        step();
        pal_we = 1'b1; pal_addr = 4'd6; pal_data = 10'b0110_101_010;
        ovr_val = 4'd6; color = 4'd6;
        step();
        pal_we = 1'b0;
        check("pal6_same_edge_old", 32'({y, cr, cb}), 32'(10'h064));
        step();
        step();
        check("pal6_next_tick_new", 32'({y, cr, cb}), 32'(10'h1AA));
        ovr = 0;

        wait_pos(10, 5);
        check("pre_reset_underflow", 32'(underflow), 32'(1));
        reset_cycles(3);
        step();
        check("post_reset_fs_edge1", 32'(frame_start), 32'(0));
        step();
        check("post_reset_fs_first_tick", 32'(frame_start), 32'(1));
        wait_pos(12, 4);
        check("post_reset_pal5_black", 32'({y, cr, cb}), 32'(10'h064));
        check("post_reset_de", 32'(de), 32'(1));
        check("post_reset_rd_addr", 32'(rd_addr), 32'(8));
        wait_pos(13, 4);
        check("post_reset_pal6_black", 32'({y, cr, cb}), 32'(10'h064));

        check("clock_out_pattern_errors", 32'(clk_bad), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
